lighthouse_pulse_decoder: RTL and testbench

Decodes the raw signal of one lighthouse photodiode into timestamped pulse records for the Avalon sensor bridge. It sits between the sensor pin and the bridge's register file: it synchronises and deglitches the input, measures each pulse against the shared 32-bit free-running timer, and classifies the pulse as sync or sweep. Sweep pulses are tagged with their offset from the last non-skip sync. Records leave through a single-entry valid/ready output register.

---
 rtl/lighthouse_pkg.sv | 52 +++++
 rtl/lighthouse_deglitch.sv | 54 +++++
 rtl/lighthouse_pulse_decoder.sv | 164 ++++++++++++++++
 tb/tb_lighthouse_pulse_decoder.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lighthouse_pkg.sv
// Shared types, field widths and 50 MHz timing defaults for the
// lighthouse photodiode pulse decoder.
package lighthouse_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    SYNC  = 1'b1
  } pulse_type_e;

  typedef enum logic [1:0] {
    WAIT_LOW,
    ARMED,
    IN_PULSE
  } lh_state_e;

  localparam int DUR_W  = 16;
  localparam int TS_W   = 32;
  localparam int DROP_W = 8;

  localparam int GLITCH_CYCLES_DEF    = 4;
  localparam int SYNC_MIN_CYCLES_DEF  = 2500;
  localparam int SYNC_BASE_CYCLES_DEF = 3125;
  localparam int SYNC_STEP_CYCLES_DEF = 521;
  localparam int MAX_PULSE_CYCLES_DEF = 10000;

  typedef struct packed {
    pulse_type_e      ptype;
    logic             axis;
    logic             data;
    logic             skip;
    logic             pref;
    logic [DUR_W-1:0] dur;
    logic [TS_W-1:0]  ticks;
  } pulse_rec_t;

  // Thresholds sit halfway between nominal bin lengths.
  function automatic logic [2:0] sync_bin(
    input logic [TS_W-1:0] dur,
    input int              base,
    input int              step
  );
    logic [2:0] bin;
    bin = '0;
    for (int k = 1; k <= 7; k++) begin
      if (dur >= TS_W'(base - step / 2 + k * step)) begin
        bin = bin + 3'd1;
      end
    end
    return bin;
  endfunction

endpackage

// File: rtl/lighthouse_deglitch.sv
// Two-flop synchroniser plus GLITCH_CYCLES-sample level filter
// with registered rise/fall strobes on the filtered level.
module lighthouse_deglitch import lighthouse_pkg::*; #(
  parameter int GLITCH_CYCLES = GLITCH_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sensor,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW =
    (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(GLITCH_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // Line is presumed high out of reset so a pulse already in
  // progress is never measured; a low line simply settles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_sensor};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
        r_rise  <= r_sync[1];
        r_fall  <= !r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/lighthouse_pulse_decoder.sv
// Lighthouse pulse decoder: timestamps, classifies and queues pulses.
// Define LH_SYNC_DECODE_EN to enable sync bin (axis/data/skip) decoding.
module lighthouse_pulse_decoder import lighthouse_pkg::*; #(
  parameter int GLITCH_CYCLES    = GLITCH_CYCLES_DEF,
  parameter int SYNC_MIN_CYCLES  = SYNC_MIN_CYCLES_DEF,
`ifdef LH_SYNC_DECODE_EN
  parameter int SYNC_BASE_CYCLES = SYNC_BASE_CYCLES_DEF,
  parameter int SYNC_STEP_CYCLES = SYNC_STEP_CYCLES_DEF,
`endif
  parameter int MAX_PULSE_CYCLES = MAX_PULSE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sensor_i,
  input  logic [TS_W-1:0]   timer_i,
  output logic              pulse_valid_o,
  input  logic              pulse_ready_i,
  output logic              pulse_type_o,
  output logic              pulse_axis_o,
  output logic              pulse_data_o,
  output logic              pulse_skip_o,
  output logic [DUR_W-1:0]  pulse_duration_o,
  output logic [TS_W-1:0]   sweep_ticks_o,
  output logic              pulse_ref_o,
  output logic [DROP_W-1:0] drop_count_o
);

  lh_state_e         r_state;
  lh_state_e         w_state_nxt;
  logic              w_level;
  logic              w_rise;
  logic              w_fall;
  logic              w_capture;
  logic              w_done;
  logic              w_timeout;
  logic              w_ref_upd;
  logic              w_drop;
  logic [TS_W-1:0]   w_elapsed;
  logic [TS_W-1:0]   r_rise_ts;
  logic [TS_W-1:0]   r_ref_ts;
  logic              r_ref_seen;
  logic              r_valid;
  logic [DROP_W-1:0] r_drop;
  pulse_rec_t        r_rec;
  pulse_rec_t        w_rec;

  lighthouse_deglitch #(
    .GLITCH_CYCLES(GLITCH_CYCLES)
  ) u_deglitch (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_sensor(sensor_i),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_elapsed = timer_i - r_rise_ts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_LOW;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Timeout wins over a coincident fall so dur always fits 16 bits.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      WAIT_LOW: begin
        if (!w_level) begin
          w_state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (w_rise) begin
          w_capture   = 1'b1;
          w_state_nxt = IN_PULSE;
        end
      end
      IN_PULSE: begin
        if (w_elapsed > TS_W'(MAX_PULSE_CYCLES)) begin
          w_timeout   = 1'b1;
          w_state_nxt = WAIT_LOW;
        end else if (w_fall) begin
          w_done      = 1'b1;
          w_state_nxt = ARMED;
        end
      end
      default: begin
        w_state_nxt = WAIT_LOW;
      end
    endcase
  end

  always_comb begin
    w_rec     = '0;
    w_ref_upd = 1'b0;
    w_rec.dur = w_elapsed[DUR_W-1:0];
    if (w_elapsed >= TS_W'(SYNC_MIN_CYCLES)) begin
      w_rec.ptype = SYNC;
`ifdef LH_SYNC_DECODE_EN
      {w_rec.skip, w_rec.data, w_rec.axis} =
        sync_bin(w_elapsed, SYNC_BASE_CYCLES, SYNC_STEP_CYCLES);
      w_ref_upd = !w_rec.skip;
`else
      w_ref_upd = 1'b1;
`endif
    end else begin
      w_rec.ptype = SWEEP;
      w_rec.pref  = r_ref_seen;
      if (r_ref_seen) begin
        w_rec.ticks = r_rise_ts - r_ref_ts;
      end
    end
  end

  assign w_drop = w_timeout
                | (w_done & r_valid & ~pulse_ready_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise_ts  <= '0;
      r_ref_ts   <= '0;
      r_ref_seen <= 1'b0;
      r_valid    <= 1'b0;
      r_rec      <= '0;
      r_drop     <= '0;
    end else begin
      if (w_capture) begin
        r_rise_ts <= timer_i;
      end
      if (w_done && w_ref_upd) begin
        r_ref_ts   <= r_rise_ts;
        r_ref_seen <= 1'b1;
      end
      if (w_done && (!r_valid || pulse_ready_i)) begin
        r_valid <= 1'b1;
        r_rec   <= w_rec;
      end else if (pulse_ready_i) begin
        r_valid <= 1'b0;
      end
      if (w_drop && (r_drop != '1)) begin
        r_drop <= r_drop + 1'b1;
      end
    end
  end

  assign pulse_valid_o    = r_valid;
  assign pulse_type_o     = r_rec.ptype;
  assign pulse_axis_o     = r_rec.axis;
  assign pulse_data_o     = r_rec.data;
  assign pulse_skip_o     = r_rec.skip;
  assign pulse_duration_o = r_rec.dur;
  assign sweep_ticks_o    = r_rec.ticks;
  assign pulse_ref_o      = r_rec.pref;
  assign drop_count_o     = r_drop;

endmodule

// File: tb/tb_lighthouse_pulse_decoder.sv
// Bench for lighthouse_pulse_decoder: table vectors, corner
// sequences and random pulses against a behavioural model.
module tb_lighthouse_pulse_decoder;

`ifdef LH_SYNC_DECODE_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  typedef struct packed {
    logic        ptype;
    logic        axis;
    logic        data;
    logic        skip;
    logic        pref;
    logic [15:0] dur;
    logic [31:0] ticks;
  } rec_t;

  typedef struct {
    int         w;
    logic       ptype;
    logic [2:0] bin;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        sensor;
  logic [31:0] timer;
  logic        tmr_load;
  logic [31:0] tmr_preset;
  logic        valid;
  logic        ready;
  logic        ptype;
  logic        axis;
  logic        data;
  logic        skip;
  logic [15:0] dur;
  logic [31:0] ticks;
  logic        pref;
  logic [7:0]  drops;

  int vectors;
  int miscompares;
  int rd_idx;
  rec_t got_q[$];

  bit          ref_seen_m;
  logic [31:0] ref_t_m;
  int          drops_m;

  lighthouse_pulse_decoder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sensor_i        (sensor),
    .timer_i         (timer),
    .pulse_valid_o   (valid),
    .pulse_ready_i   (ready),
    .pulse_type_o    (ptype),
    .pulse_axis_o    (axis),
    .pulse_data_o    (data),
    .pulse_skip_o    (skip),
    .pulse_duration_o(dur),
    .sweep_ticks_o   (ticks),
    .pulse_ref_o     (pref),
    .drop_count_o    (drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tmr_load) timer <= tmr_preset;
    else          timer <= timer + 32'd1;
  end

  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      got_q.push_back({ptype, axis, data, skip, pref, dur, ticks});
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  task automatic cmp_rec(input string nm, input rec_t a, input rec_t e);
    chk({nm, "_type"},  32'(a.ptype), 32'(e.ptype));
    chk({nm, "_axis"},  32'(a.axis),  32'(e.axis));
    chk({nm, "_data"},  32'(a.data),  32'(e.data));
    chk({nm, "_skip"},  32'(a.skip),  32'(e.skip));
    chk({nm, "_ref"},   32'(a.pref),  32'(e.pref));
    chk({nm, "_dur"},   32'(a.dur),   32'(e.dur));
    chk({nm, "_ticks"}, a.ticks,      e.ticks);
  endtask

  // Reference model: a pulse of w cycles that rose at timer rt.
  function automatic rec_t model_pulse(input int w, input logic [31:0] rt);
    rec_t e;
    int   bin;
    e   = '0;
    bin = 0;
    e.dur = 16'(w);
    if (w >= 2500) begin
      e.ptype = 1'b1;
      for (int k = 1; k <= 7; k++) begin
        if (w >= 3125 - 521 / 2 + k * 521) bin++;
      end
      if (DEC) {e.skip, e.data, e.axis} = 3'(bin);
      if (!DEC || bin < 4) begin
        ref_seen_m = 1'b1;
        ref_t_m    = rt;
      end
    end else begin
      e.pref  = ref_seen_m;
      e.ticks = ref_seen_m ? rt - ref_t_m : 32'd0;
    end
    return e;
  endfunction

  task automatic drive_pulse(input int w, output logic [31:0] rt);
    sensor = 1'b1;
    rt     = timer;
    tick(w);
    sensor = 1'b0;
  endtask

  task automatic wait_rec(input string nm, output bit ok);
    int t;
    t = 0;
    while (got_q.size() <= rd_idx && t < 40) begin
      tick(1);
      t++;
    end
    ok = (got_q.size() > rd_idx);
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no record within 40 cycles", nm);
    end
  endtask

  task automatic preset_timer(input logic [31:0] v);
    tmr_preset = v;
    tmr_load   = 1'b1;
    tick(1);
    tmr_load   = 1'b0;
  endtask

  task automatic pulse_and_check(input string nm, input int w,
                                 output rec_t e);
    logic [31:0] rt;
    bit          ok;
    drive_pulse(w, rt);
    e = model_pulse(w, rt);
    wait_rec(nm, ok);
    if (ok) begin
      cmp_rec(nm, got_q[rd_idx], e);
      rd_idx++;
    end
    tick(12);
  endtask

  vec_t tbl[9];

  initial begin
    rec_t        e;
    rec_t        ea;
    logic [31:0] rt;
    logic [31:0] rs;
    bit          ok;
    int          t;
    int          nq;

    tbl[0] = '{300,  1'b0, 3'd0};
    tbl[1] = '{2499, 1'b0, 3'd0};
    tbl[2] = '{2500, 1'b1, 3'd0};
    tbl[3] = '{3386, 1'b1, 3'd1};
    tbl[4] = '{4167, 1'b1, 3'd2};
    tbl[5] = '{4428, 1'b1, 3'd3};
    tbl[6] = '{4949, 1'b1, 3'd4};
    tbl[7] = '{6512, 1'b1, 3'd7};
    tbl[8] = '{1000, 1'b0, 3'd0};

    vectors     = 0;
    miscompares = 0;
    rd_idx      = 0;
    ref_seen_m  = 1'b0;
    ref_t_m     = '0;
    drops_m     = 0;
    rst_n       = 1'b0;
    sensor      = 1'b0;
    ready       = 1'b1;
    tmr_load    = 1'b1;
    tmr_preset  = 32'd1000;
    tick(3);
    tmr_load = 1'b0;

    chk("rst_valid", 32'(valid), 0);
    chk("rst_drop",  32'(drops), 0);
    chk("rst_dur",   32'(dur),   0);
    chk("rst_ticks", ticks,      0);
    rst_n = 1'b1;
    tick(20);

    // 2-cycle spike must be filtered out.
    sensor = 1'b1;
    tick(2);
    sensor = 1'b0;
    tick(40);
    chk("glitch_norec", 32'(got_q.size()), 32'(rd_idx));
    chk("glitch_drop",  32'(drops), 0);

    for (int i = 0; i < 9; i++) begin
      logic [2:0] eb;
      eb = DEC ? tbl[i].bin : 3'd0;
      drive_pulse(tbl[i].w, rt);
      e = model_pulse(tbl[i].w, rt);
      wait_rec("tbl", ok);
      if (ok) begin
        chk("tbl_type", 32'(got_q[rd_idx].ptype), 32'(tbl[i].ptype));
        chk("tbl_axis", 32'(got_q[rd_idx].axis),  32'(eb[0]));
        chk("tbl_data", 32'(got_q[rd_idx].data),  32'(eb[1]));
        chk("tbl_skip", 32'(got_q[rd_idx].skip),  32'(eb[2]));
        chk("tbl_dur",  32'(got_q[rd_idx].dur),   32'(tbl[i].w));
        chk("tbl_ref",  32'(got_q[rd_idx].pref),  32'(e.pref));
        chk("tbl_ticks", got_q[rd_idx].ticks,     e.ticks);
        rd_idx++;
      end
      tick(12);
    end

    // Non-skip sync, then sweep 200000 cycles later.
    drive_pulse(2600, rs);
    e = model_pulse(2600, rs);
    wait_rec("ref_sync", ok);
    if (ok) begin
      cmp_rec("ref_sync", got_q[rd_idx], e);
      rd_idx++;
    end
    tick(12);
    preset_timer(rs + 32'd200000);
    drive_pulse(300, rt);
    e = model_pulse(300, rt);
    wait_rec("sweep200k", ok);
    if (ok) begin
      chk("sweep200k_ticks", got_q[rd_idx].ticks, 32'd200000);
      chk("sweep200k_ref",   32'(got_q[rd_idx].pref), 1);
      chk("sweep200k_dur",   32'(got_q[rd_idx].dur),  300);
      chk("sweep200k_type",  32'(got_q[rd_idx].ptype), 0);
      rd_idx++;
    end
    tick(12);

    preset_timer(32'hFFFF_FF00);
    pulse_and_check("wrap", 500, e);

    // Backpressure: first record held, second dropped.
    ready = 1'b0;
    drive_pulse(300, rt);
    ea = model_pulse(300, rt);
    t = 0;
    while (!valid && t < 40) begin
      tick(1);
      t++;
    end
    chk("bp_valid_a", 32'(valid), 1);
    tick(10);
    drive_pulse(400, rt);
    drops_m++;
    tick(20);
    chk("bp_hold_valid", 32'(valid), 1);
    chk("bp_hold_dur",   32'(dur),   300);
    chk("bp_hold_ticks", ticks,      ea.ticks);
    chk("bp_drop",       32'(drops), 32'(drops_m));
    ready = 1'b1;
    wait_rec("bp_release", ok);
    if (ok) begin
      cmp_rec("bp_release", got_q[rd_idx], ea);
      rd_idx++;
    end
    tick(20);
    chk("bp_no_second", 32'(got_q.size()), 32'(rd_idx));

    // Over-long pulse times out.
    nq = got_q.size();
    drive_pulse(12000, rt);
    drops_m++;
    tick(40);
    chk("timeout_norec", 32'(got_q.size()), 32'(nq));
    chk("timeout_drop",  32'(drops), 32'(drops_m));
    pulse_and_check("post_timeout", 700, e);

    for (int i = 0; i < 12; i++) begin
      int w;
      if ($urandom_range(0, 2) == 0) w = $urandom_range(2500, 5600);
      else                           w = $urandom_range(5, 1500);
      pulse_and_check("rand", w, e);
      tick($urandom_range(0, 30));
    end

    // Reset in the middle of a pulse.
    sensor = 1'b1;
    tick(100);
    rst_n = 1'b0;
    tick(2);
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_drop",  32'(drops), 0);
    chk("midrst_dur",   32'(dur),   0);
    chk("midrst_type",  32'(ptype), 0);
    rst_n      = 1'b1;
    ref_seen_m = 1'b0;
    drops_m    = 0;
    nq         = got_q.size();
    tick(200);
    sensor = 1'b0;
    tick(40);
    chk("midrst_norec", 32'(got_q.size()), 32'(nq));
    chk("midrst_drop2", 32'(drops), 0);
    pulse_and_check("post_reset", 250, e);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
